// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings and frame-timing constants
// common to the transmitter and receiver.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int START_TICKS = 16;
  localparam int NB_DATA_DEF = 8;
  localparam int NB_STOP_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB-first, NB_STOP stop bits,
// paced by the shared 16x oversampling tick.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | line high, ready for a new word
// ST_START | start bit (low) for START_TICKS ticks
// ST_DATA  | shift[0] on the line, 16 ticks per bit
// ST_STOP  | line high for NB_STOP_TICKS ticks, then o_done
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_STOP       = NB_STOP_DEF,
  parameter int NB_STOP_TICKS = 16 * NB_STOP
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_done
);

  localparam int CNT_W = $clog2(NB_STOP_TICKS);
  localparam int BIT_W = $clog2(NB_DATA);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TICKS - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(NB_STOP_TICKS - 1);
  localparam logic [BIT_W-1:0] NBIT_LAST  = BIT_W'(NB_DATA - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [BIT_W-1:0]   n_bit, n_bit_next;
  logic [NB_DATA-1:0] shift, shift_next;
  logic               done_next;
  logic               tx_next;
  logic               tx_q, done_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      n_bit  <= '0;
      shift  <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      n_bit  <= n_bit_next;
      shift  <= shift_next;
      tx_q   <= tx_next;
      done_q <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    n_bit_next = n_bit;
    shift_next = shift;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_valid) begin
          shift_next = i_data;
          cnt_next   = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (cnt == START_LAST) begin
            cnt_next   = '0;
            n_bit_next = '0;
            state_next = ST_DATA;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (cnt == BIT_LAST) begin
            cnt_next   = '0;
            shift_next = shift >> 1;
            if (n_bit == NBIT_LAST) state_next = ST_STOP;
            else                    n_bit_next = n_bit + 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (cnt == STOP_LAST) begin
            cnt_next   = '0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: begin
        // corrupted state vector recovers to an idle line
        state_next = ST_IDLE;
        cnt_next   = '0;
        n_bit_next = '0;
      end
    endcase
  end

  // line level is decoded from the next state so o_tx can be a flop
  always_comb begin
    tx_next = 1'b1;
    o_ready = (state == ST_IDLE);
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase
  end

  assign o_tx   = tx_q;
  assign o_done = done_q;

endmodule
